dff_scan_ctrl: RTL and testbench

//  Sequencer for a scan chain of CHAIN_LEN D flip-flops (dff_p cells with a scan mux).
//  On start it shifts a load vector into the chain, pulses one functional capture,

---
 rtl/dff_scan_ctrl.sv | 118 +++++++++++
 tb/tb_dff_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_scan_ctrl.sv
// rtl/dff_scan_ctrl.sv - scan-chain sequencer: shift in, capture, shift out, present result
// Optional SCAN_CMP_EN adds exp_vec compare and a registered mismatch flag.
module dff_scan_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_vec,
  input  logic                 scan_out,
`ifdef SCAN_CMP_EN
  input  logic [CHAIN_LEN-1:0] exp_vec,
  output logic                 mismatch,
`endif
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 capture_en,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result_vec
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_IN  = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_SHIFT_OUT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] load_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_next;
  logic                 last;
`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;
`endif

  assign last     = (cnt == CNT_W'(CHAIN_LEN - 1));
  // Tail bit arrives first, so sample j ends up at bit j after CHAIN_LEN shifts.
  assign cap_next = {scan_out, cap_q[CHAIN_LEN-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      load_q     <= '0;
      cap_q      <= '0;
      result_vec <= '0;
`ifdef SCAN_CMP_EN
      exp_q      <= '0;
      mismatch   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SHIFT_IN;
            cnt    <= '0;
            load_q <= load_vec;
`ifdef SCAN_CMP_EN
            exp_q  <= exp_vec;
`endif
          end
        end
        S_SHIFT_IN: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            load_q <= load_q >> 1;
            if (last) begin
              state <= S_CAPTURE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_CAPTURE: begin
          state <= abort ? S_IDLE : S_SHIFT_OUT;
          cnt   <= '0;
        end
        S_SHIFT_OUT: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cap_q <= cap_next;
            if (last) begin
              // Commit on the edge into DONE so result is valid alongside the done pulse.
              state      <= S_DONE;
              cnt        <= '0;
              result_vec <= cap_next;
`ifdef SCAN_CMP_EN
              mismatch   <= (cap_next != exp_q);
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign scan_en    = (state == S_SHIFT_IN) || (state == S_SHIFT_OUT);
  assign scan_in    = (state == S_SHIFT_IN) && load_q[0];
  assign capture_en = (state == S_CAPTURE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_dff_scan_ctrl.sv
// tb/tb_dff_scan_ctrl.sv - directed bench for dff_scan_ctrl with an 8-bit chain model
// Chain model capture loads D = ~element.
module tb_dff_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] load_vec;
  logic       scan_out;
  logic       scan_en;
  logic       scan_in;
  logic       capture_en;
  logic       busy;
  logic       done;
  logic [7:0] result_vec;
`ifdef SCAN_CMP_EN
  logic [7:0] exp_vec;
  logic       mismatch;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] chain = 8'h00;

  dff_scan_ctrl #(.CHAIN_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .load_vec   (load_vec),
    .scan_out   (scan_out),
`ifdef SCAN_CMP_EN
    .exp_vec    (exp_vec),
    .mismatch   (mismatch),
`endif
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .capture_en (capture_en),
    .busy       (busy),
    .done       (done),
    .result_vec (result_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element 7 is the head, element 0 the tail.
  always @(posedge clk) begin
    if (scan_en)         chain <= {scan_in, chain[7:1]};
    else if (capture_en) chain <= ~chain;
  end
  assign scan_out = chain[0];

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_vec = 8'h00;
`ifdef SCAN_CMP_EN
    exp_vec = 8'h00;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({scan_en, scan_in, capture_en, busy, done} !== 5'b0 || result_vec !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ctrl=%b result=%h required ctrl=00000 result=00",
               {scan_en, scan_in, capture_en, busy, done}, result_vec);
    end
`ifdef SCAN_CMP_EN
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_mismatch: got %b required 0", mismatch);
    end
`endif
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || scan_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: busy=%b done=%b scan_en=%b required 0 0 0", c, busy, done, scan_en);
      end
    end
  endtask

  task automatic test_single_scan();
    logic [7:0] v;
    v = 8'hA5;
    load_vec = v; start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; load_vec = 8'h00; end
      if (c <= 8) begin
        checks++;
        if (scan_en !== 1'b1 || capture_en !== 1'b0 || scan_in !== v[c-1]) begin
          errors++;
          $display("FAIL shift_in c%0d: scan_en=%b cap=%b scan_in=%b required 1 0 %b",
                   c, scan_en, capture_en, scan_in, v[c-1]);
        end
      end else if (c == 9) begin
        checks++;
        if (capture_en !== 1'b1 || scan_en !== 1'b0 || scan_in !== 1'b0) begin
          errors++;
          $display("FAIL capture c9: cap=%b scan_en=%b scan_in=%b required 1 0 0", capture_en, scan_en, scan_in);
        end
      end else if (c <= 17) begin
        checks++;
        if (scan_en !== 1'b1 || capture_en !== 1'b0 || scan_in !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL shift_out c%0d: scan_en=%b cap=%b scan_in=%b done=%b required 1 0 0 0",
                   c, scan_en, capture_en, scan_in, done);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || result_vec !== 8'h5A) begin
          errors++;
          $display("FAIL single_done c18: done=%b busy=%b result=%h required 1 1 5a", done, busy, result_vec);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result_vec !== 8'h5A) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b result=%h required 0 0 5a", done, busy, result_vec);
    end
  endtask

  task automatic test_back_to_back();
    load_vec = 8'hFF; start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (c == 1) load_vec = 8'h00;
      if (c == 18) begin
        checks++;
        if (done !== 1'b1 || result_vec !== 8'h00) begin
          errors++;
          $display("FAIL b2b_first c18: done=%b result=%h required 1 00", done, result_vec);
        end
      end else if (c == 19) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap c19: busy=%b done=%b required 0 0", busy, done);
        end
      end else if (c == 20) begin
        checks++;
        if (busy !== 1'b1 || scan_en !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart c20: busy=%b scan_en=%b required 1 1", busy, scan_en);
        end
        start = 1'b0;
      end else if (c == 37) begin
        checks++;
        if (done !== 1'b1 || result_vec !== 8'hFF) begin
          errors++;
          $display("FAIL b2b_second c37: done=%b result=%h required 1 ff", done, result_vec);
        end
      end else if (c == 38) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_end c38: busy=%b required 0", busy);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy c%0d: done=%b busy=%b required 0 1", c, done, busy);
        end
      end
    end
  endtask

  task automatic test_abort();
    load_vec = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    checks++;
    if (result_vec !== 8'h5A) begin
      errors++;
      $display("FAIL abort_prior: result=%h required 5a", result_vec);
    end
    load_vec = 8'h3C; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || scan_en !== 1'b0 || capture_en !== 1'b0 || done !== 1'b0 || result_vec !== 8'h5A) begin
      errors++;
      $display("FAIL abort_idle: busy=%b scan_en=%b cap=%b done=%b result=%h required 0 0 0 0 5a",
               busy, scan_en, capture_en, done, result_vec);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result_vec !== 8'h5A) begin
        errors++;
        $display("FAIL abort_hold c%0d: done=%b busy=%b result=%h required 0 0 5a", c, done, busy, result_vec);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_vec !== 8'h5A) begin
      errors++;
      $display("FAIL abort_in_idle: busy=%b result=%h required 0 5a", busy, result_vec);
    end
  endtask

  task automatic test_async_reset();
    load_vec = 8'h81; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_en, scan_in, capture_en, busy, done} !== 5'b0 || result_vec !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b result=%h required 00000 00",
               {scan_en, scan_in, capture_en, busy, done}, result_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_vec = 8'h3C; start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || result_vec !== 8'hC3) begin
      errors++;
      $display("FAIL post_reset_scan: done=%b result=%h required 1 c3", done, result_vec);
    end
  endtask

`ifdef SCAN_CMP_EN
  task automatic test_compare();
    logic [7:0] ev [2];
    logic       em [2];
    ev[0] = 8'hF0; em[0] = 1'b0;
    ev[1] = 8'hF1; em[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      load_vec = 8'h0F; exp_vec = ev[t]; start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        if (c == 1) begin start = 1'b0; exp_vec = 8'h00; end
      end
      checks++;
      if (done !== 1'b1 || result_vec !== 8'hF0 || mismatch !== em[t]) begin
        errors++;
        $display("FAIL compare_%0d: done=%b result=%h mismatch=%b required 1 f0 %b",
                 t, done, result_vec, mismatch, em[t]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_scan();
    test_back_to_back();
    test_abort();
    test_async_reset();
`ifdef SCAN_CMP_EN
    test_compare();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
